// File: rtl/sw_pkg.sv
// sw_pkg: shared base codes, ASCII constants, FSM states and base encoder for db_streamer
package sw_pkg;
  localparam logic [1:0] BASE_A = 2'b10, BASE_G = 2'b11, BASE_T = 2'b00, BASE_C = 2'b01;
  localparam logic [7:0] LF = 8'h0A, CR = 8'h0D, GT = 8'h3E;
  typedef enum logic [1:0] {IDLE, HEADER, SEQ, GAP} state_t;
  typedef struct packed {
    logic       legal;
    logic [1:0] code;
  } base_t;
  function automatic base_t ascii_to_base(input logic [7:0] c);
    base_t r;
    logic [7:0] u;
    u = c & 8'hDF;
    r.legal = u == 8'h41 || u == 8'h43 || u == 8'h47 || u == 8'h54;
    r.code = u == 8'h41 ? BASE_A : u == 8'h43 ? BASE_C : u == 8'h47 ? BASE_G : BASE_T;
    return r;
  endfunction
endpackage

// File: rtl/tag_fifo.sv
// tag_fifo: synchronous FIFO of sequence IDs awaiting a score; push and pop may coincide even when full
module tag_fifo #(
  parameter int W = 8,
  parameter int D = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);
  localparam int AW = $clog2(D);
  logic [W-1:0] mem [D];
  logic [AW-1:0] wp, rp;
  logic [AW:0] cnt;
  logic do_push, do_pop;
  assign empty = cnt == '0;
  assign full = cnt == (AW+1)'(D);
  assign do_pop = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout = mem[rp];
  always_ff @(posedge clk)
    if (do_push) mem[wp] <= din;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      wp <= '0;
      rp <= '0;
      cnt <= '0;
    end else begin
      wp <= wp + AW'(do_push);
      rp <= rp + AW'(do_pop);
      cnt <= cnt + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
endmodule

// File: rtl/db_streamer.sv
// db_streamer: FASTA byte stream to 2-bit base strobes for the scoring array,
// with per-sequence ID tags paired back to the array's unbiased scores
module db_streamer
  import sw_pkg::*;
#(
  parameter int SCORE_WIDTH = 12,
  parameter int ZERO = 2 ** (SCORE_WIDTH - 1),
  parameter int ID_WIDTH = 8,
  parameter int TAG_DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [7:0]             char_in,
  input  logic                   char_valid,
  output logic                   char_ready,
  output logic [1:0]             data_out,
  output logic                   en_out,
  input  logic [SCORE_WIDTH-1:0] score_in,
  input  logic                   score_vld,
  output logic [ID_WIDTH-1:0]    result_id,
  output logic [SCORE_WIDTH-1:0] result_score,
  output logic                   result_valid,
  output logic                   err_bad_char,
  output logic                   err_orphan
);
  state_t state;
  base_t bb;
  logic live, vld_q, any, acc, is_lf, is_cr, bad, ev, push, full, empty;
  logic [ID_WIDTH-1:0] id, tag;
  assign bb = ascii_to_base(char_in);
  assign is_lf = char_in == LF;
  assign is_cr = char_in == CR;
  // live holds ready low while reset is asserted and for the first cycle after
  assign char_ready = live && (state == HEADER || state == SEQ || (state == IDLE && !full));
  assign acc = char_valid && char_ready;
  assign bad = acc && !is_lf && !is_cr
             && ((state == IDLE && char_in != GT) || (state == SEQ && !bb.legal));
  assign ev = score_vld && !vld_q;
  assign push = acc && state == SEQ && is_lf && any;
  tag_fifo #(.W(ID_WIDTH), .D(TAG_DEPTH)) u_tags (
    .clk(clk), .rst(rst), .push(push), .din(id), .pop(ev),
    .dout(tag), .full(full), .empty(empty)
  );
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state <= IDLE;
      live <= 1'b0;
      vld_q <= 1'b0;
      any <= 1'b0;
      id <= '0;
      data_out <= '0;
      en_out <= 1'b0;
      result_id <= '0;
      result_score <= '0;
      result_valid <= 1'b0;
      err_bad_char <= 1'b0;
      err_orphan <= 1'b0;
    end else begin
      live <= 1'b1;
      vld_q <= score_vld;
      en_out <= acc && state == SEQ && bb.legal;
      if (acc && state == SEQ && bb.legal) data_out <= bb.code;
      result_valid <= ev && !empty;
      if (ev && !empty) begin
        result_id <= tag;
        result_score <= score_in + SCORE_WIDTH'(ZERO);
      end
      if (ev && empty) err_orphan <= 1'b1;
      if (bad) err_bad_char <= 1'b1;
      case (state)
        IDLE: if (acc && char_in == GT) state <= HEADER;
        HEADER: if (acc && is_lf) state <= SEQ;
        SEQ:
          if (acc && is_lf) begin
            state <= GAP;
            id <= id + 1'b1;
            any <= 1'b0;
          end else if (acc && bb.legal) any <= 1'b1;
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_db_streamer.sv
// tb_db_streamer: scoreboard bench for db_streamer; expected bases and results are queued at stimulus time
module tb_db_streamer;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [7:0] char_in = '0;
  logic char_valid = 1'b0;
  logic char_ready;
  logic [1:0] data_out;
  logic en_out;
  logic [11:0] score_in = '0;
  logic score_vld = 1'b0;
  logic [7:0] result_id;
  logic [11:0] result_score;
  logic result_valid, err_bad_char, err_orphan;
  int checks = 0;
  int errors = 0;
  int next_id = 0;
  int run = 0;
  int last_run = 0;
  int tagq[$];
  logic [1:0] exp_base[$];
  logic [19:0] exp_res[$];
  logic [1:0] eb;
  logic [19:0] er;

  db_streamer dut (
    .clk(clk), .rst(rst), .char_in(char_in), .char_valid(char_valid), .char_ready(char_ready),
    .data_out(data_out), .en_out(en_out), .score_in(score_in), .score_vld(score_vld),
    .result_id(result_id), .result_score(result_score), .result_valid(result_valid),
    .err_bad_char(err_bad_char), .err_orphan(err_orphan)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (en_out === 1'b1) begin
      run++;
      checks++;
      if (exp_base.size() == 0) begin
        errors++;
        $display("FAIL en_out unexpected, data_out=%b", data_out);
      end else begin
        eb = exp_base.pop_front();
        if (data_out !== eb) begin
          errors++;
          $display("FAIL data_out got %b want %b", data_out, eb);
        end
      end
    end else begin
      if (run != 0) last_run = run;
      run = 0;
    end
    if (result_valid === 1'b1) begin
      checks++;
      if (exp_res.size() == 0) begin
        errors++;
        $display("FAIL result_valid unexpected, id=%0d score=%h", result_id, result_score);
      end else begin
        er = exp_res.pop_front();
        if ({result_id, result_score} !== er) begin
          errors++;
          $display("FAIL result got id=%0d score=%h want id=%0d score=%h",
                   result_id, result_score, er[19:12], er[11:0]);
        end
      end
    end
  end

  function automatic int enc(input logic [7:0] c);
    case (c)
      "A", "a": return 2;
      "C", "c": return 1;
      "G", "g": return 3;
      "T", "t": return 0;
      default: return -1;
    endcase
  endfunction

  task automatic send(input logic [7:0] b);
    int n;
    char_in = b;
    char_valid = 1'b1;
    n = 0;
    while (char_ready !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (char_ready !== 1'b1) begin
      checks++;
      errors++;
      $display("FAIL send_timeout char_ready got %b want 1 for byte %h", char_ready, b);
    end
    @(negedge clk);
  endtask

  task automatic seq(input string hdr, input string bases);
    bit any = 0;
    for (int i = 0; i < hdr.len(); i++) send(hdr[i]);
    send(8'h0A);
    for (int i = 0; i < bases.len(); i++) begin
      if (enc(bases[i]) >= 0) begin
        exp_base.push_back(2'(enc(bases[i])));
        any = 1;
      end
      send(bases[i]);
    end
    send(8'h0A);
    char_valid = 1'b0;
    if (any) tagq.push_back(next_id);
    next_id = (next_id + 1) % 256;
  endtask

  task automatic score_edge(input logic [11:0] s, input int hold);
    if (tagq.size() != 0) exp_res.push_back({8'(tagq.pop_front()), 12'(s + 12'h800)});
    score_in = s;
    score_vld = 1'b1;
    repeat (hold) @(negedge clk);
    score_vld = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic drained(input string name);
    checks++;
    if (exp_base.size() != 0 || exp_res.size() != 0) begin
      errors++;
      $display("FAIL %s pending bases=%0d results=%0d want 0 0", name, exp_base.size(), exp_res.size());
    end
  endtask

  task automatic test_reset;
    #1 rst = 1'b0;
    #2;
    checks++;
    if ({char_ready, data_out, en_out, result_id, result_score, result_valid, err_bad_char, err_orphan} !== '0) begin
      errors++;
      $display("FAIL reset outputs got %b want 0",
               {char_ready, data_out, en_out, result_id, result_score, result_valid, err_bad_char, err_orphan});
    end
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (char_ready !== 1'b1) begin
      errors++;
      $display("FAIL idle_ready got %b want 1", char_ready);
    end
  endtask

  task automatic test_basic;
    for (int i = 0; i < 3; i++) send(i == 0 ? 8'h3E : i == 1 ? "s" : "0");
    send(8'h0A);
    for (int i = 0; i < 4; i++) begin
      exp_base.push_back(i == 0 ? 2'b10 : i == 1 ? 2'b01 : i == 2 ? 2'b11 : 2'b00);
      send(i == 0 ? "A" : i == 1 ? "C" : i == 2 ? "G" : "T");
    end
    send(8'h0A);
    checks++;
    if (char_ready !== 1'b0 || en_out !== 1'b0) begin
      errors++;
      $display("FAIL gap got ready=%b en=%b want 0 0", char_ready, en_out);
    end
    char_valid = 1'b0;
    tagq.push_back(next_id);
    next_id++;
    @(negedge clk);
    checks++;
    if (last_run != 4) begin
      errors++;
      $display("FAIL en_run got %0d want 4", last_run);
    end
    drained("basic");
  endtask

  task automatic test_score_hold;
    score_edge(12'h805, 3);
    drained("score_hold");
  endtask

  task automatic test_bad_char;
    checks++;
    if (err_bad_char !== 1'b0) begin
      errors++;
      $display("FAIL bad_char_before got %b want 0", err_bad_char);
    end
    seq(">h", "acNgt");
    @(negedge clk);
    checks++;
    if (err_bad_char !== 1'b1) begin
      errors++;
      $display("FAIL bad_char got %b want 1", err_bad_char);
    end
    score_edge(12'h7FF, 1);
    drained("bad_char");
  endtask

  task automatic test_full;
    for (int i = 0; i < 4; i++) seq(">h", "A");
    char_in = 8'h3E;
    char_valid = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (char_ready !== 1'b0) begin
      errors++;
      $display("FAIL full_ready got %b want 0", char_ready);
    end
    score_edge(12'h001, 1);
    seq("h", "A");
    score_edge(12'h000, 2);
    score_edge(12'hFFF, 1);
    score_edge(12'h123, 1);
    score_edge(12'h7FF, 1);
    drained("full");
  endtask

  task automatic test_empty_seq;
    seq(">x", "");
    seq(">y", "T");
    score_edge(12'h0AB, 1);
    checks++;
    if (err_orphan !== 1'b0) begin
      errors++;
      $display("FAIL orphan_before got %b want 0", err_orphan);
    end
    score_edge(12'h0CD, 2);
    checks++;
    if (err_orphan !== 1'b1) begin
      errors++;
      $display("FAIL orphan got %b want 1", err_orphan);
    end
    drained("empty_seq");
  endtask

  task automatic test_reset_mid;
    send(8'h3E);
    send("m");
    send(8'h0A);
    exp_base.push_back(2'b10);
    send("A");
    exp_base.push_back(2'b01);
    send("C");
    checks++;
    if (en_out !== 1'b1) begin
      errors++;
      $display("FAIL pre_reset_en got %b want 1", en_out);
    end
    #1 rst = 1'b0;
    char_valid = 1'b0;
    #1;
    checks++;
    if ({en_out, result_valid, err_bad_char, err_orphan, char_ready} !== 5'b0) begin
      errors++;
      $display("FAIL mid_reset got en=%b rv=%b bad=%b orph=%b rdy=%b want 0",
               en_out, result_valid, err_bad_char, err_orphan, char_ready);
    end
    tagq.delete();
    next_id = 0;
    @(negedge clk);
    rst = 1'b1;
    seq(">z", "G");
    checks++;
    if (data_out !== 2'b11) begin
      errors++;
      $display("FAIL hold_data got %b want 11", data_out);
    end
    score_edge(12'h900, 1);
    drained("reset_mid");
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_basic();
    test_score_hold();
    test_bad_char();
    test_full();
    test_empty_seq();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/db_streamer.md
Name: db_streamer

Overview:
- Transmit-side front end for the Smith-Waterman scoring array.
- Accepts a FASTA byte stream, ASCII, one char per handshake, and encodes each nucleotide to 2 bits.
- Streams bases with an enable strobe into the array's data/enable inputs, with one mandatory idle cycle between sequences.
- Tags each in-flight sequence with an ID and pairs the array's score (vld) back to that ID, removing the score bias.

Parameters:
- SCORE_WIDTH, 12, score width in bits.
- ZERO, 2**(SCORE_WIDTH-1), score bias added back on output.
- ID_WIDTH, 8, sequence ID width.
- TAG_DEPTH, 4, outstanding-sequence tag FIFO depth (power of 2).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- char_in  in  8  ASCII FASTA byte.
- char_valid  in  1  char_in valid.
- char_ready  out  1  byte accepted when char_valid && char_ready.
- data_out  out  2  encoded base: A=10, G=11, T=00, C=01.
- en_out  out  1  data_out valid; drives the array enable.
- score_in  in  SCORE_WIDTH  biased signed score from the array.
- score_vld  in  1  array result valid; may be held high for several cycles.
- result_id  out  ID_WIDTH  ID of the sequence scored.
- result_score  out  SCORE_WIDTH  score_in + ZERO, modulo 2^SCORE_WIDTH.
- result_valid  out  1  one-cycle pulse.
- err_bad_char  out  1  sticky: illegal byte dropped.
- err_orphan  out  1  sticky: score arrived with no tag outstanding.

Behaviour:
- Reset: every output is 0, FSM goes to IDLE, ID counter is 0, tag FIFO is empty.
- FSM states: IDLE, HEADER, SEQ, GAP.
  - IDLE: '>' goes to HEADER. LF and CR (8'h0D) are ignored. Any other byte is dropped and sets err_bad_char.
  - HEADER: all bytes are discarded. LF goes to SEQ.
  - SEQ:
    - A/C/G/T, upper or lower case: data_out = encoding, en_out = 1 on the cycle after acceptance. Latency is exactly 1 cycle.
    - Any other byte except CR and LF is dropped, sets err_bad_char, and produces no en_out.
    - LF ends the sequence and goes to GAP. If at least one base was emitted, the current ID is pushed to the tag FIFO. The ID counter increments either way, wrapping at 2^ID_WIDTH.
  - GAP: lasts exactly one cycle with en_out = 0 and char_ready = 0, then goes to IDLE.
- Sequences are single-line; LF always terminates a sequence.
- char_ready:
  - 1 in HEADER and SEQ.
  - 0 in GAP.
  - In IDLE, 0 if the tag FIFO is full, otherwise 1.
- en_out is 0 in every cycle that did not follow an accepted base (bubbles are allowed mid-sequence when char_valid is low).
- data_out holds its last value when en_out = 0.
- Score capture:
  - Only the rising edge of score_vld (registered previous value 0, current 1) is a result event.
  - On the event the FIFO is popped; result_valid pulses the next cycle with result_id = popped tag and result_score = score_in + ZERO, sampled on the edge cycle.
  - Event with the FIFO empty: no pulse, err_orphan is set.
- Simultaneous push and pop, including when the FIFO is full, are both performed. Count is unchanged and ordering is preserved.
- Error flags clear only on reset.
- Reset mid-sequence: outputs return to reset values immediately. The array must also be reset by its owner.

Decomposition:
- sw_pkg holds:
  - base codes BASE_A/G/T/C;
  - ASCII constants LF, CR, GT;
  - state enum;
  - function ascii_to_base returning a 2-bit code plus a legal flag.
- One sub-module: tag_fifo, a synchronous FIFO of width ID_WIDTH and depth TAG_DEPTH, with full, empty and simultaneous push/pop support.

Test Plan:
- Bytes ">s0\nACGT\n" with char_valid continuous -> en_out high 4 consecutive cycles, data_out 10,01,11,00, then one cycle en_out=0; tag 0 pushed.
- After the above, score_vld rises with score_in = 12'h805, held 3 cycles -> exactly one result_valid pulse with result_id=0 and result_score=12'h005.
- Sequence "acNgt" -> data_out 10,01,11,00 (N dropped, no en_out for it), err_bad_char=1.
- Five headers each followed by "A\n", no scores returned -> char_ready low in IDLE after the 4th GAP. One score_vld edge -> result_id=0, and the 5th sequence is then accepted.
- ">x\n\n" (empty sequence) then ">y\nT\n" -> no tag for ID 0, tag 1 pushed. score_vld edge -> result_id=1. A further edge -> err_orphan=1, no pulse.
- rst low mid-SEQ after 2 bases -> en_out, result_valid and error flags are 0 immediately. After release, ">z\nG\n" -> result_id=0, data_out=11.
